// File: rtl/mips_pkg.sv
// Constants shared by the single-cycle MIPS datapath blocks.
// These cover the register file, control unit, destination select mux and ALU.
package mips_pkg;
   localparam int         DATA_W   = 32;
   localparam int         ADDR_W   = 5;
   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_RA   = 5'd31;  // jal link target
   localparam logic [4:0] REG_SP   = 5'd29;
endpackage

// File: rtl/reg_file_32.sv
// MIPS general-purpose register file: two combinational read ports, one synchronous write port,
// a debug read port and a count of committed writes. $0 is hard-wired to zero.
module reg_file_32 #(
   parameter int DATA_W = mips_pkg::DATA_W,
   parameter int ADDR_W = mips_pkg::ADDR_W,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic [CNT_W-1:0]  wr_count
);
   import mips_pkg::*;

   localparam int                NREGS = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO  = ADDR_W'(REG_ZERO);

   logic [DATA_W-1:0] regs [NREGS];
   logic [NREGS-1:1]  wen;
   logic              wr_commit;
   logic [CNT_W-1:0]  cnt_reg;

   // One-hot write decode; entry 0 has no enable, so $0 can never be written.
   genvar gi;
   generate
      for (gi = 1; gi < NREGS; gi++) begin : g_dec
         assign wen[gi] = we && (waddr == ADDR_W'(gi));
      end
   endgenerate

   assign wr_commit = we && (waddr != ZERO);

   // Flops rather than RAM: every entry must clear asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         cnt_reg <= '0;
      end else begin
         for (int i = 1; i < NREGS; i++) begin
            if (wen[i]) regs[i] <= wdata;
         end
         if (wr_commit) cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

   // No write bypass: wdata depends combinationally on these reads in the datapath.
   assign rdata1   = (raddr1   == ZERO) ? '0 : regs[raddr1];
   assign rdata2   = (raddr2   == ZERO) ? '0 : regs[raddr2];
   assign dbg_data = (dbg_addr == ZERO) ? '0 : regs[dbg_addr];
   assign wr_count = cnt_reg;

endmodule

// File: tb/tb_reg_file_32.sv
// Randomised scoreboard bench for reg_file_32 (counter narrowed to 4 bits to exercise wrap).
module tb_reg_file_32;
   localparam int CW = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        we;
   logic [4:0]  waddr, raddr1, raddr2, dbg_addr;
   logic [31:0] wdata, rdata1, rdata2, dbg_data;
   logic [CW-1:0] wr_count;

   reg_file_32 #(.DATA_W(32), .ADDR_W(5), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wr_count(wr_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [4:0]  a1, a2, ad;
      logic [31:0] e1, e2, ed;
      int          ec;
   } exp_t;

   exp_t        exp_q[$];
   int          total = 0;
   int          bad = 0;
   int          txn = 0;
   logic [31:0] mdl [32];
   int          mcnt;

   function automatic logic [31:0] mread(input logic [4:0] a);
      return (a == 5'd0) ? 32'd0 : mdl[a];
   endfunction

   task automatic mclear();
      for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
      mcnt = 0;
   endtask

   // Push the expected view of the current inputs, as the model sees it now.
   task automatic expect_now(input int id);
      exp_t e;
      e.id = id; e.a1 = raddr1; e.a2 = raddr2; e.ad = dbg_addr;
      e.e1 = mread(raddr1); e.e2 = mread(raddr2); e.ed = mread(dbg_addr);
      e.ec = mcnt;
      exp_q.push_back(e);
   endtask

   // One clock: drive at negedge, check before the edge, apply model, check after.
   task automatic step(input int id, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d);
      @(negedge clk);
      we = w; waddr = wa; wdata = wd; raddr1 = r1; raddr2 = r2; dbg_addr = d;
      #1 expect_now(id);
      @(posedge clk);
      if (rst_n === 1'b1 && w === 1'b1 && wa !== 5'd0) begin
         mdl[wa] = wd;
         mcnt = (mcnt + 1) % (1 << CW);
      end
      #1 expect_now(id);
   endtask

   // Monitor: compares each expected view as soon as it is presented.
   initial begin
      exp_t e;
      forever begin
         wait (exp_q.size() != 0);
         e = exp_q.pop_front();
         txn++;
         $display("txn %0d id=%0d r1[%0d]=%h r2[%0d]=%h dbg[%0d]=%h cnt=%0d",
                  txn, e.id, e.a1, rdata1, e.a2, rdata2, e.ad, dbg_data, wr_count);
         total += 4;
         if (rdata1 !== e.e1) begin bad++; $display("FAIL rdata1 id=%0d got=%h want=%h", e.id, rdata1, e.e1); end
         if (rdata2 !== e.e2) begin bad++; $display("FAIL rdata2 id=%0d got=%h want=%h", e.id, rdata2, e.e2); end
         if (dbg_data !== e.ed) begin bad++; $display("FAIL dbg_data id=%0d got=%h want=%h", e.id, dbg_data, e.ed); end
         if (int'(wr_count) !== e.ec) begin bad++; $display("FAIL wr_count id=%0d got=%0d want=%0d", e.id, wr_count, e.ec); end
      end
   end

   initial begin
      mclear();
      rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
      raddr1 = 5'd5; raddr2 = 5'd31; dbg_addr = 5'd17;
      #1 expect_now(0);
      @(negedge clk); rst_n = 1'b1;

      // basic write/read, $0 protection, same-cycle read of the written register
      step(1, 1'b1, 5'd8, 32'hDEADBEEF, 5'd8, 5'd8, 5'd8);
      step(2, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
      step(3, 1'b1, 5'd3, 32'd1, 5'd3, 5'd3, 5'd3);
      step(4, 1'b1, 5'd3, 32'd2, 5'd8, 5'd3, 5'd3);

      // we gating, including unknown address/data with we low
      step(5, 1'b1, 5'd9, 32'h0000_1111, 5'd9, 5'd9, 5'd9);
      for (int k = 0; k < 4; k++) step(6, 1'b0, 5'd9, 32'hAAAA5555, 5'd9, 5'd8, 5'd9);
      step(7, 1'b0, 5'bxxxxx, 32'hxxxxxxxx, 5'd9, 5'd3, 5'd8);

      // full sweep then read-back on every port
      for (int i = 1; i < 32; i++)
         step(8, 1'b1, 5'(i), i * 32'h01010101, 5'(i), 5'($urandom_range(0, 31)), 5'(i));
      for (int i = 0; i < 32; i++)
         step(9, 1'b0, 5'($urandom_range(0, 31)), $urandom, 5'(i), 5'(31 - i), 5'(i));

      // randomised traffic
      for (int k = 0; k < 200; k++)
         step(10, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
              5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));

      // async reset mid-cycle with a write pending; cleared before any edge, write lost
      step(11, 1'b1, 5'd5, 32'h12345678, 5'd5, 5'd5, 5'd5);
      #2;
      we = 1'b1; waddr = 5'd5; wdata = 32'hCAFEF00D; raddr1 = 5'd5; raddr2 = 5'd8; dbg_addr = 5'd31;
      rst_n = 1'b0;
      mclear();
      #1 expect_now(12);
      @(posedge clk);
      #1 expect_now(13);
      @(negedge clk); rst_n = 1'b1; we = 1'b0;

      // 17 commits from reset: 4-bit counter wraps to 1
      for (int i = 1; i <= 17; i++)
         step(14, 1'b1, 5'(i), $urandom, 5'(i), 5'd0, 5'(i));

      for (int k = 0; k < 10 && exp_q.size() != 0; k++) #1;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain pending=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
